fifo_fwft_reader: RTL and testbench

- Read-side drain engine for the team's sync/async FIFO wrappers. Drives the FIFO's rd_en/rd_oce, absorbs the RAM read latency and presents a first-word-fall-through valid/ready stream to downstream logic.
- Sits in the read clock domain, directly on the FIFO read port (rd_data/rd_empty).
- Sustains one word per cycle with no combinational path from m_ready to fifo_rd_en.

---
 rtl/fifo_fwft_reader.sv | 117 +++++++++++
 tb/tb_fifo_fwft_reader.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_reader.sv
// Read-side drain engine: issues FIFO reads against buffer credit and
// presents a first-word-fall-through valid/ready stream.
module fifo_fwft_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    localparam int BUF_DEPTH = RD_LATENCY + 2,
    localparam int LW = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  flush,
    output logic                  fifo_rd_en,
    output logic                  fifo_rd_oce,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LW-1:0]         m_level
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [LW-1:0]         inflight;
    logic [LW:0]           credit;
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic                  rd_en;
    logic                  push;
    logic                  pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + LW'(pipe_q[i]);
        end
    end

    // Credit covers buffered plus in-flight words, so no m_ready term is needed.
    assign credit = {1'b0, level_q} + {1'b0, inflight};
    assign rd_en  = rd_rst_n && !fifo_rd_empty && !flush &&
                    (credit < (LW + 1)'(BUF_DEPTH));

    assign push = pipe_q[RD_LATENCY-1];
    assign pop  = m_valid && m_ready;

    assign fifo_rd_en  = rd_en;
    assign fifo_rd_oce = 1'b1;
    assign m_valid     = (level_q != '0);
    assign m_data      = mem_q[rd_ptr_q];
    assign m_level     = level_q;

    always_comb begin
        pipe_d = '0;
        if (!flush) begin
            pipe_d[0] = rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = fifo_rd_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pipe_q   <= pipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

    overflow_a: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        !(push && !flush && !pop && (level_q == LW'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo_fwft_reader.sv
// Directed and randomized checks of fifo_fwft_reader at both read latencies.
`timescale 1ns/1ps
module tb_fifo_fwft_reader;

    localparam int MASK = 16383;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  flush, m_ready, rd_en, oce, empty, m_valid;
    logic [31:0] rd_data [2];
    logic [31:0] m_data [2];
    logic [1:0]  lvl0;
    logic [2:0]  lvl1;
    logic [2:0]  lvl [2];
    logic [31:0] fm [2][0:MASK];
    int          wcnt [2];
    int          rcnt [2];
    logic [31:0] d1 [2];
    logic [31:0] d2 [2];
    int          n_chk;
    int          n_fail;

    fifo_fwft_reader #(.DATA_WIDTH(32), .RD_LATENCY(1)) u_l1 (
        .rd_clk(clk), .rd_rst_n(rst_n), .flush(flush[0]),
        .fifo_rd_en(rd_en[0]), .fifo_rd_oce(oce[0]),
        .fifo_rd_empty(empty[0]), .fifo_rd_data(rd_data[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .m_data(m_data[0]), .m_level(lvl0)
    );

    fifo_fwft_reader #(.DATA_WIDTH(32), .RD_LATENCY(2)) u_l2 (
        .rd_clk(clk), .rd_rst_n(rst_n), .flush(flush[1]),
        .fifo_rd_en(rd_en[1]), .fifo_rd_oce(oce[1]),
        .fifo_rd_empty(empty[1]), .fifo_rd_data(rd_data[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .m_data(m_data[1]), .m_level(lvl1)
    );

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            empty[l] = (wcnt[l] == rcnt[l]);
        end
        lvl[0]     = {1'b0, lvl0};
        lvl[1]     = lvl1;
        rd_data[0] = d1[0];
        rd_data[1] = d2[1];
    end

    // FIFO model: lane 0 has no output register, lane 1 has one
    always @(posedge clk or negedge rst_n) begin
        for (int l = 0; l < 2; l++) begin
            if (!rst_n) begin
                rcnt[l] <= wcnt[l];
                d1[l]   <= '0;
                d2[l]   <= '0;
            end else begin
                if (rd_en[l]) begin
                    d1[l]   <= fm[l][rcnt[l] & MASK];
                    rcnt[l] <= rcnt[l] + 1;
                end
                if (oce[l]) d2[l] <= d1[l];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic put(input int l, input logic [31:0] v);
        fm[l][wcnt[l] & MASK] = v;
        wcnt[l] = wcnt[l] + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        put(0, 32'hdead);
        put(1, 32'hbeef);
        samp();
        for (int l = 0; l < 2; l++) begin
            n_chk++;
            if (m_valid[l] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid lane%0d: got %b expected 0", l, m_valid[l]);
            end
            n_chk++;
            if (lvl[l] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_level lane%0d: got %0d expected 0", l, lvl[l]);
            end
            n_chk++;
            if (rd_en[l] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rd_en lane%0d: got %b expected 0", l, rd_en[l]);
            end
            n_chk++;
            if (m_data[l] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_data lane%0d: got %h expected 0", l, m_data[l]);
            end
            n_chk++;
            if (oce[l] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_oce lane%0d: got %b expected 1", l, oce[l]);
            end
        end
        step();
        rst_n = 1'b1;
        samp();
        for (int l = 0; l < 2; l++) begin
            n_chk++;
            if (rd_en[l] !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_rd_en lane%0d: got %b expected 0", l, rd_en[l]);
            end
        end
        step();
    endtask

    task automatic test_stream_l1();
        m_ready[0] = 1'b1;
        step();
        for (int k = 0; k < 8; k++) put(0, 32'(k));
        for (int i = 0; i <= 10; i++) begin
            logic ev;
            samp();
            ev = (i >= 2 && i <= 9);
            n_chk++;
            if (m_valid[0] !== ev) begin
                n_fail++;
                $display("FAIL stream_valid cyc%0d: got %b expected %b", i, m_valid[0], ev);
            end
            if (ev) begin
                n_chk++;
                if (m_data[0] !== 32'(i - 2)) begin
                    n_fail++;
                    $display("FAIL stream_data cyc%0d: got %h expected %h", i, m_data[0], i - 2);
                end
            end
            n_chk++;
            if (lvl[0] > 3'd1) begin
                n_fail++;
                $display("FAIL stream_level cyc%0d: got %0d expected <=1", i, lvl[0]);
            end
            step();
        end
    endtask

    task automatic test_fill_l2();
        int cnt;
        m_ready[1] = 1'b0;
        step();
        for (int k = 0; k < 16; k++) put(1, 32'h100 + 32'(k));
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            samp();
            if (rd_en[1]) cnt++;
            step();
        end
        n_chk++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL fill_reads: got %0d expected 4", cnt);
        end
        samp();
        n_chk++;
        if (lvl[1] !== 3'd4 || rd_en[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got level %0d rd_en %b expected level 4 rd_en 0",
                     lvl[1], rd_en[1]);
        end
        n_chk++;
        if (m_valid[1] !== 1'b1 || m_data[1] !== 32'h100) begin
            n_fail++;
            $display("FAIL fill_head: got v%b %h expected v1 00000100", m_valid[1], m_data[1]);
        end
        step();
        m_ready[1] = 1'b1;
        for (int j = 0; j < 16; j++) begin
            samp();
            n_chk++;
            if (m_valid[1] !== 1'b1 || m_data[1] !== 32'h100 + 32'(j)) begin
                n_fail++;
                $display("FAIL drain_word%0d: got v%b %h expected v1 %h",
                         j, m_valid[1], m_data[1], 32'h100 + 32'(j));
            end
            step();
        end
        samp();
        n_chk++;
        if (m_valid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_end: got %b expected 0", m_valid[1]);
        end
        step();
    endtask

    task automatic test_empty_refill(input int l);
        int ex;
        int lat;
        lat = l + 1;
        m_ready[l] = 1'b1;
        step();
        for (int k = 0; k < 6; k++) put(l, 32'(k));
        ex = 0;
        for (int c = 0; c < 30 && ex < 6; c++) begin
            samp();
            if (m_valid[l]) begin
                n_chk++;
                if (m_data[l] !== 32'(ex)) begin
                    n_fail++;
                    $display("FAIL burst_data lane%0d: got %h expected %h", l, m_data[l], ex);
                end
                ex++;
            end
            step();
        end
        n_chk++;
        if (ex != 6) begin
            n_fail++;
            $display("FAIL burst_timeout lane%0d: got %0d words expected 6", l, ex);
        end
        samp();
        n_chk++;
        if (m_valid[l] !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_drop lane%0d: got %b expected 0", l, m_valid[l]);
        end
        step();
        put(l, 32'h6);
        for (int i = 0; i <= lat; i++) begin
            samp();
            n_chk++;
            if (m_valid[l] !== 1'b0) begin
                n_fail++;
                $display("FAIL refill_early lane%0d cyc%0d: got %b expected 0", l, i, m_valid[l]);
            end
            step();
        end
        samp();
        n_chk++;
        if (m_valid[l] !== 1'b1 || m_data[l] !== 32'h6) begin
            n_fail++;
            $display("FAIL refill_word lane%0d: got v%b %h expected v1 00000006",
                     l, m_valid[l], m_data[l]);
        end
        step();
    endtask

    task automatic test_flush();
        int ex;
        m_ready[1] = 1'b0;
        step();
        for (int k = 0; k < 6; k++) put(1, 32'h200 + 32'(k));
        for (int i = 0; i < 3; i++) begin
            samp();
            step();
        end
        flush[1] = 1'b1;
        samp();
        n_chk++;
        if (lvl[1] !== 3'd1 || rd_en[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: got level %0d rd_en %b expected level 1 rd_en 0",
                     lvl[1], rd_en[1]);
        end
        step();
        flush[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            samp();
            n_chk++;
            if (m_valid[1] !== 1'b0 || lvl[1] !== 3'd0) begin
                n_fail++;
                $display("FAIL flush_after cyc%0d: got v%b level %0d expected v0 level 0",
                         i, m_valid[1], lvl[1]);
            end
            step();
        end
        samp();
        n_chk++;
        if (m_valid[1] !== 1'b1 || m_data[1] !== 32'h203) begin
            n_fail++;
            $display("FAIL flush_next: got v%b %h expected v1 00000203", m_valid[1], m_data[1]);
        end
        step();
        m_ready[1] = 1'b1;
        ex = 3;
        for (int c = 0; c < 20 && ex < 6; c++) begin
            samp();
            if (m_valid[1]) begin
                n_chk++;
                if (m_data[1] !== 32'h200 + 32'(ex)) begin
                    n_fail++;
                    $display("FAIL flush_drain: got %h expected %h", m_data[1], 32'h200 + 32'(ex));
                end
                ex++;
            end
            step();
        end
        n_chk++;
        if (ex != 6) begin
            n_fail++;
            $display("FAIL flush_timeout: got %0d expected 6", ex);
        end
    endtask

    task automatic test_async_reset();
        m_ready[0] = 1'b1;
        step();
        for (int k = 0; k < 10; k++) put(0, 32'h500 + 32'(k));
        for (int i = 0; i < 4; i++) step();
        #2;
        n_chk++;
        if (m_valid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got %b expected 1", m_valid[0]);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (m_valid[0] !== 1'b0 || rd_en[0] !== 1'b0 || lvl[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL arst_now: got v%b rd_en %b level %0d expected all 0",
                     m_valid[0], rd_en[0], lvl[0]);
        end
        step();
        step();
        rst_n = 1'b1;
        samp();
        n_chk++;
        if (m_valid[0] !== 1'b0 || rd_en[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_release: got v%b rd_en %b expected 0 0", m_valid[0], rd_en[0]);
        end
        step();
        for (int k = 0; k < 3; k++) put(0, 32'h600 + 32'(k));
        for (int i = 0; i < 6; i++) begin
            logic ev;
            samp();
            ev = (i >= 2 && i <= 4);
            n_chk++;
            if (m_valid[0] !== ev || (ev && m_data[0] !== 32'h600 + 32'(i - 2))) begin
                n_fail++;
                $display("FAIL arst_resume cyc%0d: got v%b %h expected v%b %h",
                         i, m_valid[0], m_data[0], ev, 32'h600 + 32'(i - 2));
            end
            step();
        end
    endtask

    task automatic test_random();
        int          pcnt [2];
        int          got [2];
        int          wleft [2];
        logic        pv [2];
        logic        pr [2];
        logic [31:0] pd [2];
        logic [31:0] ex;
        step();
        flush = 2'b11;
        m_ready = 2'b00;
        step();
        flush = 2'b00;
        samp();
        for (int l = 0; l < 2; l++) begin
            pcnt[l]  = rcnt[l];
            got[l]   = 0;
            wleft[l] = 10000;
            pv[l]    = 1'b0;
            pr[l]    = 1'b0;
            pd[l]    = '0;
        end
        for (int c = 0; c < 60000 && (got[0] < 10000 || got[1] < 10000); c++) begin
            step();
            for (int l = 0; l < 2; l++) begin
                m_ready[l] = 1'($urandom_range(0, 1));
                if (wleft[l] > 0 && (wcnt[l] - rcnt[l]) < 6 && $urandom_range(0, 3) != 0) begin
                    put(l, $urandom);
                    wleft[l]--;
                end
            end
            samp();
            for (int l = 0; l < 2; l++) begin
                if (pv[l] && !pr[l]) begin
                    n_chk++;
                    if (m_valid[l] !== 1'b1 || m_data[l] !== pd[l]) begin
                        n_fail++;
                        $display("FAIL stall_hold lane%0d: got v%b %h expected v1 %h",
                                 l, m_valid[l], m_data[l], pd[l]);
                    end
                end
                if (m_valid[l] && m_ready[l]) begin
                    ex = fm[l][pcnt[l] & MASK];
                    n_chk++;
                    if (m_data[l] !== ex) begin
                        n_fail++;
                        $display("FAIL rand_data lane%0d word%0d: got %h expected %h",
                                 l, got[l], m_data[l], ex);
                    end
                    pcnt[l]++;
                    got[l]++;
                end
                pv[l] = m_valid[l];
                pr[l] = m_ready[l];
                pd[l] = m_data[l];
            end
        end
        for (int l = 0; l < 2; l++) begin
            n_chk++;
            if (got[l] != 10000) begin
                n_fail++;
                $display("FAIL rand_count lane%0d: got %0d expected 10000", l, got[l]);
            end
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        flush   = 2'b00;
        m_ready = 2'b00;
        test_reset();
        test_stream_l1();
        test_fill_l2();
        test_empty_refill(0);
        test_empty_refill(1);
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
